// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for a single FFT core: config word, NFFT input beats with tlast,
// then a counted drain of the output frame with length/timeout/event error tracking.
module fft_frame_sequencer #(
    parameter int unsigned NFFT    = 1024,
    parameter int unsigned CNT_W   = 11,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CFG_W   = 8,
    parameter int unsigned TIMEOUT = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fwd_inv,
    output logic              busy,
    input  logic [DATA_W-1:0] src_tdata,
    input  logic              src_tvalid,
    output logic              src_tready,
    output logic [CFG_W-1:0]  fft_cfg_tdata,
    output logic              fft_cfg_tvalid,
    input  logic              fft_cfg_tready,
    output logic [DATA_W-1:0] fft_din_tdata,
    output logic              fft_din_tvalid,
    input  logic              fft_din_tready,
    output logic              fft_din_tlast,
    input  logic              fft_dout_tvalid,
    input  logic              fft_dout_tlast,
    output logic              fft_dout_tready,
    input  logic              evt_tlast_unexpected,
    input  logic              evt_tlast_missing,
    output logic              frame_done,
    output logic              frame_err,
    output logic [3:0]        err_flags,
    output logic [15:0]       frame_count
);

    localparam int unsigned      TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NFFT - 1);
    localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StConfig,
        StLoad,
        StDrain,
        StDone,
        StErr
    } state_e;

    state_e             state;
    logic               fwd_inv_q;
    logic [CNT_W-1:0]   in_cnt;
    logic [CNT_W-1:0]   out_cnt;
    logic [TMO_W-1:0]   tmo_cnt;

    logic               in_load;
    logic               in_drain;
    logic               in_active;
    logic               din_beat;
    logic               din_last;
    logic               dout_beat;
    logic               dout_at_last;
    logic               dout_good_end;
    logic               dout_len_err;
    logic               frame_end;
    logic               tmo_hit;
    logic [3:0]         flags_set;
    logic [3:0]         flags_nxt;

    always_comb begin
        in_load       = (state == StLoad);
        in_drain      = (state == StDrain);
        in_active     = (state == StConfig) || in_load || in_drain;
        din_beat      = in_load && src_tvalid && fft_din_tready;
        din_last      = (in_cnt == LastIdx);
        dout_beat     = in_drain && fft_dout_tvalid;
        dout_at_last  = (out_cnt == LastIdx);
        dout_good_end = dout_beat && fft_dout_tlast && dout_at_last;
        // Early tlast, or the NFFT-th beat arriving without tlast.
        dout_len_err  = dout_beat && (fft_dout_tlast ^ dout_at_last);
        frame_end     = dout_good_end || dout_len_err;
        tmo_hit       = in_drain && (tmo_cnt == TmoLast) && !frame_end;
        flags_set     = {tmo_hit, dout_len_err,
                         in_active && evt_tlast_missing,
                         in_active && evt_tlast_unexpected};
        flags_nxt     = err_flags | flags_set;
    end

    assign src_tready     = in_load && fft_din_tready;
    assign fft_din_tvalid = in_load && src_tvalid;
    assign fft_din_tlast  = in_load && din_last;
    assign fft_din_tdata  = src_tdata;
    assign fft_cfg_tdata  = {{(CFG_W - 1){1'b0}}, fwd_inv_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= StIdle;
            fwd_inv_q       <= 1'b0;
            busy            <= 1'b0;
            fft_cfg_tvalid  <= 1'b0;
            fft_dout_tready <= 1'b0;
            frame_done      <= 1'b0;
            frame_err       <= 1'b0;
            err_flags       <= 4'b0;
            frame_count     <= 16'd0;
            in_cnt          <= '0;
            out_cnt         <= '0;
            tmo_cnt         <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (in_active) begin
                err_flags <= flags_nxt;
            end

            case (state)
                StIdle: begin
                    if (start) begin
                        fwd_inv_q      <= fwd_inv;
                        err_flags      <= 4'b0;
                        busy           <= 1'b1;
                        fft_cfg_tvalid <= 1'b1;
                        state          <= StConfig;
                    end
                end

                StConfig: begin
                    if (fft_cfg_tready) begin
                        fft_cfg_tvalid <= 1'b0;
                        in_cnt         <= '0;
                        state          <= StLoad;
                    end
                end

                StLoad: begin
                    if (din_beat) begin
                        if (din_last) begin
                            in_cnt          <= '0;
                            out_cnt         <= '0;
                            tmo_cnt         <= '0;
                            fft_dout_tready <= 1'b1;
                            state           <= StDrain;
                        end else begin
                            in_cnt <= in_cnt + CNT_W'(1);
                        end
                    end
                end

                StDrain: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (dout_beat) begin
                        out_cnt <= out_cnt + CNT_W'(1);
                    end
                    if (frame_end || tmo_hit) begin
                        fft_dout_tready <= 1'b0;
                        out_cnt         <= '0;
                        tmo_cnt         <= '0;
                        frame_count     <= frame_count + 16'd1;
                        // Flags raised this very cycle must already steer to ERR.
                        if (flags_nxt == 4'b0) begin
                            frame_done <= 1'b1;
                            state      <= StDone;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= StErr;
                        end
                    end
                end

                StDone, StErr: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer: the driver queues expected cfg words, input
// beats and frame results; a negedge monitor pops and compares on every handshake or pulse.
module tb_fft_frame_sequencer;

    localparam int NFFT = 8;

    logic        clk;
    logic        rst;
    logic        start;
    logic        fwd_inv;
    logic        busy;
    logic [31:0] src_tdata;
    logic        src_tvalid;
    logic        src_tready;
    logic [7:0]  fft_cfg_tdata;
    logic        fft_cfg_tvalid;
    logic        fft_cfg_tready;
    logic [31:0] fft_din_tdata;
    logic        fft_din_tvalid;
    logic        fft_din_tready;
    logic        fft_din_tlast;
    logic        fft_dout_tvalid;
    logic        fft_dout_tlast;
    logic        fft_dout_tready;
    logic        evt_tlast_unexpected;
    logic        evt_tlast_missing;
    logic        frame_done;
    logic        frame_err;
    logic [3:0]  err_flags;
    logic [15:0] frame_count;

    fft_frame_sequencer #(
        .NFFT    (NFFT),
        .CNT_W   (4),
        .DATA_W  (32),
        .CFG_W   (8),
        .TIMEOUT (16)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .fwd_inv              (fwd_inv),
        .busy                 (busy),
        .src_tdata            (src_tdata),
        .src_tvalid           (src_tvalid),
        .src_tready           (src_tready),
        .fft_cfg_tdata        (fft_cfg_tdata),
        .fft_cfg_tvalid       (fft_cfg_tvalid),
        .fft_cfg_tready       (fft_cfg_tready),
        .fft_din_tdata        (fft_din_tdata),
        .fft_din_tvalid       (fft_din_tvalid),
        .fft_din_tready       (fft_din_tready),
        .fft_din_tlast        (fft_din_tlast),
        .fft_dout_tvalid      (fft_dout_tvalid),
        .fft_dout_tlast       (fft_dout_tlast),
        .fft_dout_tready      (fft_dout_tready),
        .evt_tlast_unexpected (evt_tlast_unexpected),
        .evt_tlast_missing    (evt_tlast_missing),
        .frame_done           (frame_done),
        .frame_err            (frame_err),
        .err_flags            (err_flags),
        .frame_count          (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  cfg_q[$];
    logic [32:0] din_q[$];   // {last, data}
    logic [20:0] frm_q[$];   // {done, flags, count}
    logic [15:0] exp_count;

    logic [7:0]  mon_cfg;
    logic [32:0] mon_din;
    logic [20:0] mon_frm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        $display("FAIL %s: got an unexpected event, required none", name);
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (fft_cfg_tvalid && fft_cfg_tready) begin
                if (cfg_q.size() == 0) begin
                    unexpected("cfg_beat");
                end else begin
                    mon_cfg = cfg_q.pop_front();
                    check("cfg_tdata", 32'(fft_cfg_tdata), 32'(mon_cfg));
                end
            end
            if (fft_din_tvalid && fft_din_tready) begin
                if (din_q.size() == 0) begin
                    unexpected("din_beat");
                end else begin
                    mon_din = din_q.pop_front();
                    check("din_tdata", fft_din_tdata, mon_din[31:0]);
                    check("din_tlast", 32'(fft_din_tlast), 32'(mon_din[32]));
                end
            end
            if (frame_done || frame_err) begin
                if (frm_q.size() == 0) begin
                    unexpected("frame_end");
                end else begin
                    mon_frm = frm_q.pop_front();
                    check("frame_done", 32'(frame_done), 32'(mon_frm[20]));
                    check("frame_err", 32'(frame_err), 32'(!mon_frm[20]));
                    check("err_flags", 32'(err_flags), 32'(mon_frm[19:16]));
                    check("frame_count", 32'(frame_count), 32'(mon_frm[15:0]));
                end
            end
        end
    end

    task automatic idle_inputs();
        start                = 1'b0;
        fwd_inv              = 1'b0;
        src_tdata            = 32'd0;
        src_tvalid           = 1'b0;
        fft_cfg_tready       = 1'b1;
        fft_din_tready       = 1'b1;
        fft_dout_tvalid      = 1'b0;
        fft_dout_tlast       = 1'b0;
        evt_tlast_unexpected = 1'b0;
        evt_tlast_missing    = 1'b0;
    endtask

    // tlast_at: 1-based output beat carrying tlast (0 = none); abort_at >= 0 stops after
    // that many input beats with no frame result expected.
    task automatic run_frame(
        input  logic        fwd,
        input  logic [31:0] base,
        input  int          cfg_wait,
        input  bit          toggle,
        input  int          stall_at,
        input  int          busy_start_at,
        input  int          evt_at,
        input  int          tlast_at,
        input  int          n_out,
        input  int          abort_at,
        input  logic [3:0]  exp_flags,
        output int          cfg_cycles,
        output int          drain_cycles,
        output int          first_beat
    );
        int idx, oidx, stalled, n_in;
        bit ended, src_fire, dout_fire, evt_sent;
        idx = 0; oidx = 0; stalled = 0; ended = 0; evt_sent = 0;
        cfg_cycles = 0; drain_cycles = 0; first_beat = -1;
        n_in = (abort_at >= 0) ? abort_at : NFFT;
        cfg_q.push_back({7'b0, fwd});
        for (int i = 0; i < n_in; i++) begin
            din_q.push_back({(i == NFFT - 1), base + 32'(i)});
        end
        if (abort_at < 0) begin
            exp_count = exp_count + 16'd1;
            frm_q.push_back({(exp_flags == 4'b0), exp_flags, exp_count});
        end

        start   = 1'b1;
        fwd_inv = fwd;
        @(posedge clk); #1;
        fwd_inv = ~fwd;
        for (int c = 0; c < 300; c++) begin
            start          = (c == busy_start_at);
            fft_cfg_tready = (c >= cfg_wait);
            fft_din_tready = toggle ? c[0] : 1'b1;
            if (idx == stall_at && stalled < 3) begin
                src_tvalid = 1'b0;
                stalled++;
            end else begin
                src_tvalid = (idx < NFFT);
            end
            src_tdata         = base + 32'(idx);
            evt_tlast_missing = (idx == evt_at) && !evt_sent;
            fft_dout_tvalid   = (idx == NFFT) && (oidx < n_out);
            fft_dout_tlast    = fft_dout_tvalid && (oidx + 1 == tlast_at);
            @(negedge clk);
            if (c == 0) begin
                check("busy_after_start", 32'(busy), 32'd1);
                check("flags_cleared", 32'(err_flags), 32'd0);
            end
            if (fft_cfg_tvalid) cfg_cycles++;
            if (fft_dout_tready) drain_cycles++;
            src_fire  = src_tvalid && src_tready;
            dout_fire = fft_dout_tvalid && fft_dout_tready;
            if (src_fire && first_beat < 0) first_beat = c;
            if (evt_tlast_missing) evt_sent = 1;
            ended = frame_done || frame_err;
            @(posedge clk); #1;
            if (src_fire) idx++;
            if (dout_fire) oidx++;
            if (ended) break;
            if (abort_at >= 0 && idx == abort_at) break;
        end
        idle_inputs();
        if (abort_at < 0) begin
            if (!ended) begin
                n_checks++;
                $display("FAIL frame_end_timeout: got no frame_done/frame_err, required one");
            end
            check("busy_fall", 32'(busy), 32'd0);
            check("din_q_empty", din_q.size(), 32'd0);
        end
    endtask

    int cfg_cyc, drain_cyc, first_cyc;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required $finish");
        $fatal(1);
    end

    initial begin
        exp_count = 16'd0;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_tvalid", 32'(fft_cfg_tvalid), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_dout_tready", 32'(fft_dout_tready), 32'd0);
        check("idle_flags", 32'(err_flags), 32'd0);

        // Clean forward frame.
        run_frame(1'b1, 32'hA000_0000, 0, 0, -1, -1, -1, 8, 8, -1, 4'b0000,
                  cfg_cyc, drain_cyc, first_cyc);
        check("t1_cfg_cycles", cfg_cyc, 32'd1);
        check("t1_first_beat", first_cyc, 32'd1);
        check("t1_drain_cycles", drain_cyc, 32'd8);
        check("t1_cfg_latched", 32'(fft_cfg_tdata), 32'h01);

        // Inverse, cfg held off, toggling din_tready, source stall, ignored busy start.
        run_frame(1'b0, 32'hB000_0000, 2, 1, 3, 5, -1, 8, 8, -1, 4'b0000,
                  cfg_cyc, drain_cyc, first_cyc);
        check("t2_cfg_cycles", cfg_cyc, 32'd3);
        check("t2_first_beat", first_cyc, 32'd3);
        check("t2_cfg_latched", 32'(fft_cfg_tdata), 32'h00);

        // Early output tlast on beat 5.
        run_frame(1'b1, 32'hC000_0000, 0, 0, -1, -1, -1, 5, 8, -1, 4'b0100,
                  cfg_cyc, drain_cyc, first_cyc);
        check("t3_drain_cycles", drain_cyc, 32'd5);

        // Core never answers: timeout after 16 drain cycles.
        run_frame(1'b1, 32'hD000_0000, 0, 0, -1, -1, -1, 0, 0, -1, 4'b1000,
                  cfg_cyc, drain_cyc, first_cyc);
        check("t4_drain_cycles", drain_cyc, 32'd16);

        // tlast_missing event during load, then a clean frame whose start clears the flags.
        run_frame(1'b1, 32'hE000_0000, 0, 0, -1, -1, 3, 8, 8, -1, 4'b0010,
                  cfg_cyc, drain_cyc, first_cyc);
        check("t5_flags_held", 32'(err_flags), 32'h2);
        run_frame(1'b0, 32'hE100_0000, 0, 0, -1, -1, -1, 8, 8, -1, 4'b0000,
                  cfg_cyc, drain_cyc, first_cyc);

        // Reset in the middle of LOAD after 4 beats.
        run_frame(1'b1, 32'hF000_0000, 0, 0, -1, -1, -1, 8, 8, 4, 4'b0000,
                  cfg_cyc, drain_cyc, first_cyc);
        src_tvalid = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_src_tready", 32'(src_tready), 32'd0);
        check("mid_rst_din_tvalid", 32'(fft_din_tvalid), 32'd0);
        check("mid_rst_din_tlast", 32'(fft_din_tlast), 32'd0);
        check("mid_rst_dout_tready", 32'(fft_dout_tready), 32'd0);
        check("mid_rst_frame_count", 32'(frame_count), 32'd0);
        check("mid_rst_flags", 32'(err_flags), 32'd0);
        check("mid_rst_din_q", din_q.size(), 32'd0);
        src_tvalid = 1'b0;
        exp_count  = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame(1'b1, 32'h1234_0000, 0, 0, -1, -1, -1, 8, 8, -1, 4'b0000,
                  cfg_cyc, drain_cyc, first_cyc);
        check("t6_cfg_cycles", cfg_cyc, 32'd1);

        repeat (2) @(posedge clk);
        check("end_cfg_q", cfg_q.size(), 32'd0);
        check("end_frm_q", frm_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
